// File: rtl/product_accumulator.sv
// Frame accumulator behind the 4-bit multiplier: sums LEN unsigned products per frame
// and presents the modulo-2^ACC_W sum plus a sticky overflow flag on a valid/ready output.
//
// state | meaning
// ACCUM | accepting products into the running frame sum (in_ready=1)
// HOLD  | completed frame result presented on acc_out/overflow (out_valid=1)
module product_accumulator #(
    parameter int LEN   = 4,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [ACC_W:0]   sum_ext;
    logic             take;
    logic             last;

    // One extra bit captures the carry out of the modulo-2^ACC_W sum.
    assign sum_ext = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, product};
    assign take    = in_valid && in_ready;
    assign last    = (cnt == CNT_LAST);

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && last) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ACCUM;
            acc      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            acc_out  <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            if (take) begin
                if (last) begin
                    acc_out  <= sum_ext[ACC_W-1:0];
                    overflow <= ovf | sum_ext[ACC_W];
                    acc      <= '0;
                    ovf      <= 1'b0;
                    cnt      <= '0;
                end else begin
                    acc <= sum_ext[ACC_W-1:0];
                    ovf <= ovf | sum_ext[ACC_W];
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three instances (default, ACC_W=9, LEN=1) checked by a
// frame-level scoreboard, a table of frame vectors and hand-written corner sequences.
module tb_product_accumulator;

    localparam int N = 3;
    localparam int LENS[N] = '{4, 4, 1};
    localparam int AWS[N]  = '{12, 9, 12};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       va = 1'b0, ra = 1'b1;
    logic [7:0] pa = '0;
    logic       v1 = 1'b0, r1 = 1'b1;
    logic [7:0] p1 = '0;

    logic [N-1:0] ir, ov, of;
    logic [11:0]  acc0, acc1;
    logic [8:0]   acc9;

    product_accumulator #(.LEN(4), .ACC_W(12)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(va), .in_ready(ir[0]), .product(pa),
        .out_valid(ov[0]), .out_ready(ra), .acc_out(acc0), .overflow(of[0]));
    product_accumulator #(.LEN(4), .ACC_W(9)) dut9 (
        .clk(clk), .rst_n(rst_n), .in_valid(va), .in_ready(ir[1]), .product(pa),
        .out_valid(ov[1]), .out_ready(ra), .acc_out(acc9), .overflow(of[1]));
    product_accumulator #(.LEN(1), .ACC_W(12)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(ir[2]), .product(p1),
        .out_valid(ov[2]), .out_ready(r1), .acc_out(acc1), .overflow(of[2]));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting at %0t", name, $time);
    endtask

    // Frame-level scoreboard: products seen crossing the input handshake are summed with
    // unbounded integer arithmetic; each LEN-th one makes a result pending.
    int psum[N], pcnt[N], exp_acc[N];
    bit exp_ovf[N], pend[N];

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            logic        iv, orr;
            logic [31:0] prod, accv;
            iv   = (i == 2) ? v1 : va;
            orr  = (i == 2) ? r1 : ra;
            prod = (i == 2) ? 32'(p1) : 32'(pa);
            accv = (i == 0) ? 32'(acc0) : (i == 1) ? 32'(acc9) : 32'(acc1);
            if (!rst_n) begin
                psum[i] = 0;
                pcnt[i] = 0;
                pend[i] = 0;
            end else begin
                chk($sformatf("sb%0d_out_valid", i), 32'(ov[i]), 32'(pend[i]));
                chk($sformatf("sb%0d_in_ready", i), 32'(ir[i]), 32'(!pend[i]));
                if (pend[i]) begin
                    chk($sformatf("sb%0d_acc_out", i), accv, 32'(exp_acc[i]));
                    chk($sformatf("sb%0d_overflow", i), 32'(of[i]), 32'(exp_ovf[i]));
                    if (orr) pend[i] = 0;
                end else if (iv) begin
                    psum[i] += int'(prod);
                    pcnt[i]++;
                    if (pcnt[i] == LENS[i]) begin
                        exp_acc[i] = psum[i] % (1 << AWS[i]);
                        exp_ovf[i] = (psum[i] >= (1 << AWS[i]));
                        pend[i]    = 1;
                        psum[i]    = 0;
                        pcnt[i]    = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] p, input int gap);
        va = 1'b1;
        pa = p;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ir[0]) break;
        end
        if (!ir[0]) timeout("send");
        tick();
        va = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_result(input string name);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ov[0]) break;
        end
        if (!ov[0]) timeout(name);
    endtask

    task automatic wait_release(input string name);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!ov[0]) break;
        end
        if (ov[0]) timeout(name);
        tick();
    endtask

    typedef struct {
        logic [7:0] p[4];
        int         gap;
        int         hold;
        int         exp12;
        bit         ovf12;
        int         exp9;
        bit         ovf9;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{p: '{8'd3, 8'd10, 8'd225, 8'd0},     gap: 0, hold: 0, exp12: 238,  ovf12: 0, exp9: 238, ovf9: 0};
        vecs[1] = '{p: '{8'd15, 8'd15, 8'd15, 8'd15},    gap: 1, hold: 5, exp12: 60,   ovf12: 0, exp9: 60,  ovf9: 0};
        vecs[2] = '{p: '{8'd225, 8'd225, 8'd225, 8'd225}, gap: 0, hold: 0, exp12: 900,  ovf12: 0, exp9: 388, ovf9: 1};
        vecs[3] = '{p: '{8'd1, 8'd2, 8'd3, 8'd4},         gap: 0, hold: 0, exp12: 10,   ovf12: 0, exp9: 10,  ovf9: 0};
        vecs[4] = '{p: '{8'd255, 8'd255, 8'd255, 8'd255}, gap: 2, hold: 1, exp12: 1020, ovf12: 0, exp9: 508, ovf9: 1};
        vecs[5] = '{p: '{8'd0, 8'd0, 8'd0, 8'd0},         gap: 0, hold: 0, exp12: 0,    ovf12: 0, exp9: 0,   ovf9: 0};

        // Reset held for two cycles.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rst%0d_in_ready", i), 32'(ir[i]), 32'd1);
            chk($sformatf("rst%0d_out_valid", i), 32'(ov[i]), 32'd0);
            chk($sformatf("rst%0d_overflow", i), 32'(of[i]), 32'd0);
        end
        chk("rst_acc0", 32'(acc0), 32'd0);
        chk("rst_acc9", 32'(acc9), 32'd0);
        chk("rst_acc1", 32'(acc1), 32'd0);

        // LEN=1: one result every two cycles.
        tick();
        v1 = 1'b1; p1 = 8'd7;
        @(negedge clk);
        chk("len1_ready0", 32'(ir[2]), 32'd1);
        tick();
        p1 = 8'd200;
        @(negedge clk);
        chk("len1_valid_a", 32'(ov[2]), 32'd1);
        chk("len1_acc_a", 32'(acc1), 32'd7);
        chk("len1_ready_hold", 32'(ir[2]), 32'd0);
        tick();
        @(negedge clk);
        chk("len1_valid_gap", 32'(ov[2]), 32'd0);
        chk("len1_ready_back", 32'(ir[2]), 32'd1);
        tick();
        v1 = 1'b0;
        @(negedge clk);
        chk("len1_valid_b", 32'(ov[2]), 32'd1);
        chk("len1_acc_b", 32'(acc1), 32'd200);
        tick();

        // Frame table on the LEN=4 pair.
        for (int r = 0; r < 6; r++) begin
            ra = (vecs[r].hold == 0);
            for (int j = 0; j < 4; j++) send(vecs[r].p[j], (j < 3) ? vecs[r].gap : 0);
            wait_result($sformatf("vec%0d_result", r));
            chk($sformatf("vec%0d_acc12", r), 32'(acc0), 32'(vecs[r].exp12));
            chk($sformatf("vec%0d_ovf12", r), 32'(of[0]), 32'(vecs[r].ovf12));
            chk($sformatf("vec%0d_acc9", r), 32'(acc9), 32'(vecs[r].exp9));
            chk($sformatf("vec%0d_ovf9", r), 32'(of[1]), 32'(vecs[r].ovf9));
            for (int h = 0; h < vecs[r].hold; h++) begin
                tick();
                va = 1'b1;
                pa = 8'($urandom);
                @(negedge clk);
                chk($sformatf("vec%0d_hold_acc", r), 32'(acc0), 32'(vecs[r].exp12));
                chk($sformatf("vec%0d_hold_valid", r), 32'(ov[0]), 32'd1);
                chk($sformatf("vec%0d_hold_ready", r), 32'(ir[0]), 32'd0);
            end
            if (vecs[r].hold > 0) begin
                tick();
                va = 1'b0;
                ra = 1'b1;
            end
            wait_release($sformatf("vec%0d_release", r));
        end

        // Reset mid-frame discards the partial sum.
        send(8'd50, 0);
        send(8'd60, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) send(8'd1, 0);
        wait_result("midrst_result");
        chk("midrst_acc12", 32'(acc0), 32'd4);
        chk("midrst_acc9", 32'(acc9), 32'd4);
        chk("midrst_ovf", 32'(of[0]), 32'd0);
        wait_release("midrst_release");

        // Reset while a result is held drops it.
        ra = 1'b0;
        for (int j = 0; j < 4; j++) send(8'd9, 0);
        wait_result("holdrst_result");
        chk("holdrst_acc_before", 32'(acc0), 32'd36);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("holdrst_valid", 32'(ov[0]), 32'd0);
        chk("holdrst_ready", 32'(ir[0]), 32'd1);
        chk("holdrst_acc", 32'(acc0), 32'd0);
        chk("holdrst_ovf", 32'(of[0]), 32'd0);
        tick();
        ra = 1'b1;

        // Random traffic, checked by the scoreboard.
        for (int c = 0; c < 600; c++) begin
            va = ($urandom_range(0, 3) != 0);
            pa = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
            ra = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 3) != 0);
            p1 = 8'($urandom);
            r1 = ($urandom_range(0, 2) != 0);
            tick();
        end
        va = 1'b0;
        v1 = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
